booth_mul16: RTL and testbench

BOOTH_MUL16 -- requirements
Module: booth_mul16

---
 rtl/booth_mul16_pkg.sv | 21 ++
 rtl/booth_step.sv | 39 +++
 rtl/booth_mul16.sv | 126 ++++++++++++
 tb/tb_booth_mul16.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/booth_mul16_pkg.sv
// Shared definitions for the signed multiply unit.
// Latency: n/a (definitions only).
// Backpressure: n/a.
//
// Holds the multiplier FSM encoding, the default RAM address of the product
// high word, and the ALU opcode that selects the multiplier.
package booth_mul16_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // Product high word is always written to this fixed RAM location.
  localparam logic [7:0] HIGH_ADDR_DEFAULT = 8'd9;

  // ALU opcode that dispatches to the multiplier.
  localparam logic [5:0] OP_SMUL = 6'b011000;

endpackage

// File: rtl/booth_step.sv
// One radix-2 Booth iteration: conditional add/subtract of M, then arithmetic shift right.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports:
//   acc, q, qM1          current {Acc, Q, q_1}; acc is WIDTH+1 bits
//   mult                 multiplicand sign-extended to WIDTH+1 bits
//   accShift, qShift,
//   qM1Shift             {Acc, Q, q_1} after the add/subtract and the shift
module booth_step #(
  parameter int WIDTH = 16
) (
  input  logic [WIDTH:0]   acc,
  input  logic [WIDTH-1:0] q,
  input  logic             qM1,
  input  logic [WIDTH:0]   mult,
  output logic [WIDTH:0]   accShift,
  output logic [WIDTH-1:0] qShift,
  output logic             qM1Shift
);

  logic [WIDTH:0] sum;

  always_comb begin
    sum = acc;
    unique case ({q[0], qM1})
      2'b01:   sum = acc + mult;
      2'b10:   sum = acc - mult;
      default: sum = acc;
    endcase
  end

  // Arithmetic shift of the concatenation {sum, q, qM1}: the sign of sum is
  // replicated, the LSB of sum moves into the top of Q, Q[0] becomes q_1.
  assign accShift = {sum[WIDTH], sum[WIDTH:1]};
  assign qShift   = {sum[0], q[WIDTH-1:1]};
  assign qM1Shift = q[0];

endmodule

// File: rtl/booth_mul16.sv
// Sequential signed multiplier (radix-2 Booth, one step per cycle) writing its product to RAM.
// Latency: start accepted at edge 0 -> oDone high after edge WIDTH+1; back-to-back starts from DONE.
// Backpressure: none; iStart is ignored while busy, callers must watch oBusy/oDone.
//
// Ports:
//   Clock, Reset             clock, asynchronous active-low reset
//   iStart, iA, iB           start request and two's complement operands
//   iDestination             RAM address for the low word, captured with the operands
//   oBusy                    high while iterating
//   oDone                    one-cycle result-valid pulse
//   oResultLow/oResultHigh   product halves, held until the next result
//   oDestination             low-word RAM write address
//   oWriteEnable             low-word RAM write strobe
//   oMulEnable               high-word RAM write strobe (address HIGH_ADDR)
module booth_mul16
  import booth_mul16_pkg::*;
#(
  parameter int         WIDTH     = 16,
  parameter logic [7:0] HIGH_ADDR = HIGH_ADDR_DEFAULT
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic             iStart,
  input  logic [WIDTH-1:0] iA,
  input  logic [WIDTH-1:0] iB,
  input  logic [7:0]       iDestination,
  output logic             oBusy,
  output logic             oDone,
  output logic [WIDTH-1:0] oResultLow,
  output logic [WIDTH-1:0] oResultHigh,
  output logic [7:0]       oDestination,
  output logic             oWriteEnable,
  output logic             oMulEnable
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           state;
  state_t           stateNext;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   acc;
  logic [WIDTH-1:0] q;
  logic             qM1;
  logic [WIDTH:0]   mult;
  logic [7:0]       destHold;

  logic [WIDTH:0]   accShift;
  logic [WIDTH-1:0] qShift;
  logic             qM1Shift;

  logic loadOp;
  logic stepOp;
  logic finishOp;

  booth_step #(.WIDTH(WIDTH)) uStep (
    .acc      (acc),
    .q        (q),
    .qM1      (qM1),
    .mult     (mult),
    .accShift (accShift),
    .qShift   (qShift),
    .qM1Shift (qM1Shift)
  );

  // A new operation may start from IDLE or straight out of DONE.
  assign loadOp   = iStart && (state == IDLE || state == DONE);
  assign stepOp   = (state == RUN) && (count != '0);
  // One extra RUN cycle after the last step commits the product to the outputs.
  assign finishOp = (state == RUN) && (count == '0);

  always_comb begin
    stateNext = state;
    unique case (state)
      IDLE:    if (iStart) stateNext = RUN;
      RUN:     if (count == '0) stateNext = DONE;
      DONE:    stateNext = iStart ? RUN : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge Clock or negedge Reset) begin
    if (!Reset) begin
      state        <= IDLE;
      count        <= '0;
      acc          <= '0;
      q            <= '0;
      qM1          <= 1'b0;
      mult         <= '0;
      destHold     <= '0;
      oResultLow   <= '0;
      oResultHigh  <= '0;
      oDestination <= '0;
    end else begin
      state <= stateNext;
      if (loadOp) begin
        mult     <= {iA[WIDTH-1], iA};
        q        <= iB;
        acc      <= '0;
        qM1      <= 1'b0;
        count    <= CW'(WIDTH);
        destHold <= iDestination;
      end else if (stepOp) begin
        acc   <= accShift;
        q     <= qShift;
        qM1   <= qM1Shift;
        count <= count - CW'(1);
      end
      if (finishOp) begin
        // acc[WIDTH] is only a guard bit; the 2*WIDTH product is {acc[WIDTH-1:0], q}.
        oResultLow   <= q;
        oResultHigh  <= acc[WIDTH-1:0];
        oDestination <= destHold;
      end
    end
  end

  assign oBusy        = (state == RUN);
  assign oDone        = (state == DONE);
  assign oWriteEnable = oDone;
  assign oMulEnable   = oDone;

  // The low-word write must never land on the fixed high-word address.
  aDestNotHigh: assert property (@(posedge Clock) disable iff (!Reset)
    oWriteEnable |-> (oDestination != HIGH_ADDR));

endmodule

// File: tb/tb_booth_mul16.sv
module tb_booth_mul16;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        iStart;
  logic [15:0] iA;
  logic [15:0] iB;
  logic [7:0]  iDestination;
  logic        oBusy;
  logic        oDone;
  logic [15:0] oResultLow;
  logic [15:0] oResultHigh;
  logic [7:0]  oDestination;
  logic        oWriteEnable;
  logic        oMulEnable;

  always #5 Clock = ~Clock;

  booth_mul16 #(.WIDTH(16), .HIGH_ADDR(8'd9)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .iStart       (iStart),
    .iA           (iA),
    .iB           (iB),
    .iDestination (iDestination),
    .oBusy        (oBusy),
    .oDone        (oDone),
    .oResultLow   (oResultLow),
    .oResultHigh  (oResultHigh),
    .oDestination (oDestination),
    .oWriteEnable (oWriteEnable),
    .oMulEnable   (oMulEnable)
  );

  typedef struct {
    logic [15:0] a;
    logic [15:0] b;
    logic [7:0]  dst;
    logic [15:0] lo;
    logic [15:0] hi;
  } vec_t;

  typedef struct {
    logic [15:0] lo;
    logic [15:0] hi;
    logic [7:0]  dst;
  } exp_t;

  exp_t sbQ[$];
  vec_t vecs[9];
  int   checks    = 0;
  int   failures  = 0;
  int   doneCount = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard side: every oDone pulse must match the oldest outstanding request.
  always @(negedge Clock) begin : monitor
    exp_t e;
    if (Reset === 1'b1) begin
      check("strobes_eq_done", 32'({oWriteEnable, oMulEnable}), 32'({oDone, oDone}));
      if (oDone === 1'b1) begin
        doneCount++;
        if (sbQ.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_done: got oDone=1 lo=%h hi=%h required no pulse", oResultLow, oResultHigh);
        end else begin
          e = sbQ.pop_front();
          check("result_low",  32'(oResultLow),   32'(e.lo));
          check("result_high", 32'(oResultHigh),  32'(e.hi));
          check("destination", 32'(oDestination), 32'(e.dst));
        end
      end
    end
  end

  task automatic tick;
    @(posedge Clock);
    #1;
  endtask

  // Drive one request (accepted at the next edge), then count edges until oDone.
  task automatic startOp(input logic [15:0] a, input logic [15:0] b, input logic [7:0] d,
                         input logic [15:0] lo, input logic [15:0] hi, output int lat);
    exp_t e;
    iA = a;
    iB = b;
    iDestination = d;
    iStart = 1'b1;
    e.lo = lo;
    e.hi = hi;
    e.dst = d;
    sbQ.push_back(e);
    tick();
    iStart = 1'b0;
    check("busy_after_accept", 32'(oBusy), 32'd1);
    lat = 0;
    for (int n = 1; n <= 40; n++) begin
      tick();
      if (oDone === 1'b1) begin
        lat = n;
        break;
      end
    end
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin : main
    int          lat;
    int          base;
    logic [15:0] ra;
    logic [15:0] rb;
    logic [31:0] prod;
    logic [7:0]  rd;

    vecs[0] = '{16'd3,    16'd5,    8'h04, 16'h000F, 16'h0000};
    vecs[1] = '{16'hFFFE, 16'd7,    8'h05, 16'hFFF2, 16'hFFFF};
    vecs[2] = '{16'h8000, 16'h8000, 8'h06, 16'h0000, 16'h4000};
    vecs[3] = '{16'h7FFF, 16'h7FFF, 8'h07, 16'h0001, 16'h3FFF};
    vecs[4] = '{16'h7FFF, 16'h8000, 8'h08, 16'h8000, 16'hC000};
    vecs[5] = '{16'hFFFF, 16'hFFFF, 8'h0A, 16'h0001, 16'h0000};
    vecs[6] = '{16'hFFFF, 16'h0001, 8'h0B, 16'hFFFF, 16'hFFFF};
    vecs[7] = '{16'h0000, 16'h1234, 8'h0C, 16'h0000, 16'h0000};
    vecs[8] = '{16'h1234, 16'hFFFF, 8'h0D, 16'hEDCC, 16'hFFFF};

    Reset = 1'b0;
    iStart = 1'b0;
    iA = '0;
    iB = '0;
    iDestination = '0;
    repeat (2) @(posedge Clock);
    #1;
    check("reset_results", {oResultHigh, oResultLow}, 32'd0);
    check("reset_dest",    32'(oDestination), 32'd0);
    check("reset_ctrl",    32'({oBusy, oDone, oWriteEnable, oMulEnable}), 32'd0);

    // First request on the first edge after reset release.
    Reset = 1'b1;
    for (int i = 0; i < 9; i++) begin
      startOp(vecs[i].a, vecs[i].b, vecs[i].dst, vecs[i].lo, vecs[i].hi, lat);
      check($sformatf("latency_vec%0d", i), 32'(lat), 32'd17);
      tick();
      check($sformatf("single_pulse_vec%0d", i), 32'({oDone, oBusy}), 32'd0);
      check($sformatf("hold_low_vec%0d", i), 32'(oResultLow), 32'(vecs[i].lo));
    end

    // Pseudo-random operands against a sign-extended multiply model.
    for (int i = 0; i < 4; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom);
      rd = 8'($urandom_range(10, 255));
      prod = $signed({{16{ra[15]}}, ra}) * $signed({{16{rb[15]}}, rb});
      startOp(ra, rb, rd, prod[15:0], prod[31:16], lat);
      check($sformatf("latency_rand%0d", i), 32'(lat), 32'd17);
      tick();
    end

    // iStart held through RUN with different operands: one pulse, first product.
    iA = 16'd100;
    iB = 16'hFFFD;
    iDestination = 8'h21;
    iStart = 1'b1;
    sbQ.push_back('{16'hFED4, 16'hFFFF, 8'h21});
    tick();
    base = doneCount;
    iA = 16'h1234;
    iB = 16'h0055;
    iDestination = 8'h77;
    repeat (17) tick();
    iStart = 1'b0;
    check("held_done_edge17", 32'(oDone), 32'd1);
    repeat (30) tick();
    check("held_one_pulse", 32'(doneCount - base), 32'd1);

    // Back-to-back: new request issued during the DONE cycle.
    startOp(16'd7, 16'd9, 8'h30, 16'h003F, 16'h0000, lat);
    check("b2b_first_latency", 32'(lat), 32'd17);
    startOp(16'd4, 16'hFFFC, 8'h31, 16'hFFF0, 16'hFFFF, lat);
    check("b2b_second_latency", 32'(lat), 32'd17);
    tick();

    // Reset eight cycles into RUN: outputs clear at once, no pulse afterwards.
    iA = 16'h0101;
    iB = 16'h0202;
    iDestination = 8'h40;
    iStart = 1'b1;
    tick();
    iStart = 1'b0;
    repeat (8) tick();
    check("abort_busy_before", 32'(oBusy), 32'd1);
    Reset = 1'b0;
    #1;
    check("abort_results", {oResultHigh, oResultLow}, 32'd0);
    check("abort_dest",    32'(oDestination), 32'd0);
    check("abort_ctrl",    32'({oBusy, oDone, oWriteEnable, oMulEnable}), 32'd0);
    #2;
    Reset = 1'b1;
    base = doneCount;
    repeat (20) tick();
    check("abort_no_done", 32'(doneCount - base), 32'd0);
    check("abort_idle", 32'(oBusy), 32'd0);

    startOp(16'hFFFB, 16'hFFFA, 8'h50, 16'd30, 16'h0000, lat);
    check("post_reset_latency", 32'(lat), 32'd17);
    repeat (3) tick();
    check("sb_drained", 32'(sbQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
